// File: rtl/rpn_stack_master.sv
// RPN evaluation controller: turns operand/operator tokens into push/pop traffic
// on an external 8-deep LIFO and pushes 4-bit ALU results back onto it.
module rpn_stack_master #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             Clk,
   input  logic             RstN,
   input  logic             Tok_Valid,
   output logic             Tok_Ready,
   input  logic             Tok_IsOp,
   input  logic [WIDTH-1:0] Tok_Data,
   output logic             St_Push,
   output logic             St_Pop,
   output logic [WIDTH-1:0] St_Data_In,
   input  logic [WIDTH-1:0] St_Data_Out,
   input  logic             St_Full,
   input  logic             St_Empty,
   output logic [WIDTH-1:0] Result,
   output logic             Result_Valid,
   output logic             Busy,
   output logic             Err,
   output logic [1:0]       Err_Code
);

   localparam int unsigned SW = 4;

   localparam logic [SW-1:0] S_IDLE      = SW'(0);
   localparam logic [SW-1:0] S_PUSH_OPND = SW'(1);
   localparam logic [SW-1:0] S_POP_B     = SW'(2);
   localparam logic [SW-1:0] S_WAIT_B    = SW'(3);
   localparam logic [SW-1:0] S_POP_A     = SW'(4);
   localparam logic [SW-1:0] S_WAIT_A    = SW'(5);
   localparam logic [SW-1:0] S_EXEC      = SW'(6);
   localparam logic [SW-1:0] S_PUSH_RES  = SW'(7);
   localparam logic [SW-1:0] S_PUSH_DUP  = SW'(8);
   localparam logic [SW-1:0] S_ERROR     = SW'(9);

   localparam logic [WIDTH-1:0] OP_ADD = WIDTH'(0);
   localparam logic [WIDTH-1:0] OP_SUB = WIDTH'(1);
   localparam logic [WIDTH-1:0] OP_AND = WIDTH'(2);
   localparam logic [WIDTH-1:0] OP_OR  = WIDTH'(3);
   localparam logic [WIDTH-1:0] OP_XOR = WIDTH'(4);
   localparam logic [WIDTH-1:0] OP_DUP = WIDTH'(5);

   localparam logic [1:0] ERR_UNDER   = 2'd1;
   localparam logic [1:0] ERR_OVER    = 2'd2;
   localparam logic [1:0] ERR_ILLEGAL = 2'd3;

   logic [SW-1:0]    state_q, state_d;
   logic [WIDTH-1:0] tok_q, tok_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             st_push_q, st_push_d;
   logic             st_pop_q, st_pop_d;
   logic [WIDTH-1:0] st_data_in_q, st_data_in_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             tok_ready_q, tok_ready_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             accept_c;

   assign accept_c = tok_ready_q & Tok_Valid;

   // Stack outputs are registered, so popped data shows up one state after the
   // matching WAIT_x state; B is taken in POP_A/PUSH_RES and A directly in EXEC.
   always_comb begin
      state_d        = state_q;
      tok_d          = tok_q;
      b_d            = b_q;
      r_d            = r_q;
      st_push_d      = 1'b0;
      st_pop_d       = 1'b0;
      st_data_in_d   = st_data_in_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      err_d          = err_q;
      err_code_d     = err_code_q;

      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               tok_d = Tok_Data;
               if (!Tok_IsOp) begin
                  state_d = S_PUSH_OPND;
               end else if (Tok_Data > OP_DUP) begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
                  if (!err_q) err_code_d = ERR_ILLEGAL;
               end else begin
                  state_d = S_POP_B;
               end
            end
         end
         S_PUSH_OPND: begin
            if (St_Full) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
               if (!err_q) err_code_d = ERR_OVER;
            end else begin
               st_push_d    = 1'b1;
               st_data_in_d = tok_q;
               state_d      = S_IDLE;
            end
         end
         S_POP_B: begin
            if (!St_Empty) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
               if (!err_q) err_code_d = ERR_UNDER;
            end else begin
               st_pop_d = 1'b1;
               state_d  = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            state_d = (tok_q == OP_DUP) ? S_PUSH_RES : S_POP_A;
         end
         S_POP_A: begin
            b_d = St_Data_Out;
            if (!St_Empty) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
               if (!err_q) err_code_d = ERR_UNDER;
            end else begin
               st_pop_d = 1'b1;
               state_d  = S_WAIT_A;
            end
         end
         S_WAIT_A: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (tok_q)
               OP_ADD:  r_d = St_Data_Out + b_q;
               OP_SUB:  r_d = St_Data_Out - b_q;
               OP_AND:  r_d = St_Data_Out & b_q;
               OP_OR:   r_d = St_Data_Out | b_q;
               OP_XOR:  r_d = St_Data_Out ^ b_q;
               default: r_d = b_q;
            endcase
            state_d = S_PUSH_RES;
         end
         S_PUSH_RES: begin
            st_push_d      = 1'b1;
            result_valid_d = 1'b1;
            if (tok_q == OP_DUP) begin
               b_d          = St_Data_Out;
               st_data_in_d = St_Data_Out;
               result_d     = St_Data_Out;
               state_d      = S_PUSH_DUP;
            end else begin
               st_data_in_d = r_q;
               result_d     = r_q;
               state_d      = S_IDLE;
            end
         end
         S_PUSH_DUP: begin
            if (St_Full) begin
               state_d = S_ERROR;
               err_d   = 1'b1;
               if (!err_q) err_code_d = ERR_OVER;
            end else begin
               st_push_d    = 1'b1;
               st_data_in_d = b_q;
               state_d      = S_IDLE;
            end
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d      = (state_d != S_IDLE);
      // Ready only once the FSM has spent a full cycle back in IDLE
      tok_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
   end

   always_ff @(posedge Clk) begin
      if (!RstN) begin
         state_q        <= S_IDLE;
         tok_q          <= '0;
         b_q            <= '0;
         r_q            <= '0;
         st_push_q      <= 1'b0;
         st_pop_q       <= 1'b0;
         st_data_in_q   <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         tok_ready_q    <= 1'b0;
         busy_q         <= 1'b0;
         err_q          <= 1'b0;
         err_code_q     <= 2'd0;
      end else begin
         state_q        <= state_d;
         tok_q          <= tok_d;
         b_q            <= b_d;
         r_q            <= r_d;
         st_push_q      <= st_push_d;
         st_pop_q       <= st_pop_d;
         st_data_in_q   <= st_data_in_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         tok_ready_q    <= tok_ready_d;
         busy_q         <= busy_d;
         err_q          <= err_d;
         err_code_q     <= err_code_d;
      end
   end

   assign Tok_Ready    = tok_ready_q;
   assign St_Push      = st_push_q;
   assign St_Pop       = st_pop_q;
   assign St_Data_In   = st_data_in_q;
   assign Result       = result_q;
   assign Result_Valid = result_valid_q;
   assign Busy         = busy_q;
   assign Err          = err_q;
   assign Err_Code     = err_code_q;

endmodule

// File: tb/tb_rpn_stack_master.sv
// Directed bench for rpn_stack_master with a behavioural 8-entry LIFO model.
module tb_rpn_stack_master;

   logic       Clk;
   logic       RstN;
   logic       Tok_Valid;
   logic       Tok_Ready;
   logic       Tok_IsOp;
   logic [3:0] Tok_Data;
   logic       St_Push;
   logic       St_Pop;
   logic [3:0] St_Data_In;
   logic [3:0] St_Data_Out;
   logic       St_Full;
   logic       St_Empty;
   logic [3:0] Result;
   logic       Result_Valid;
   logic       Busy;
   logic       Err;
   logic [1:0] Err_Code;

   rpn_stack_master #(.WIDTH(4)) dut (
      .Clk          (Clk),
      .RstN         (RstN),
      .Tok_Valid    (Tok_Valid),
      .Tok_Ready    (Tok_Ready),
      .Tok_IsOp     (Tok_IsOp),
      .Tok_Data     (Tok_Data),
      .St_Push      (St_Push),
      .St_Pop       (St_Pop),
      .St_Data_In   (St_Data_In),
      .St_Data_Out  (St_Data_Out),
      .St_Full      (St_Full),
      .St_Empty     (St_Empty),
      .Result       (Result),
      .Result_Valid (Result_Valid),
      .Busy         (Busy),
      .Err          (Err),
      .Err_Code     (Err_Code)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // LIFO model; St_Empty is high while the stack holds something
   logic [3:0] mem [8];
   logic [3:0] cnt;
   always @(posedge Clk) begin
      if (!RstN) begin
         cnt         <= 4'd0;
         St_Data_Out <= 4'd0;
      end else if (St_Push && cnt < 4'd8) begin
         mem[cnt[2:0]] <= St_Data_In;
         cnt           <= cnt + 4'd1;
      end else if (St_Pop && cnt > 4'd0) begin
         St_Data_Out <= mem[3'(cnt - 4'd1)];
         cnt         <= cnt - 4'd1;
      end
   end
   assign St_Full  = (cnt == 4'd8);
   assign St_Empty = (cnt != 4'd0);

   int total_cnt = 0;
   int pass_cnt  = 0;
   int both_viol = 0;

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   typedef struct {
      logic        is_op;
      logic [3:0]  data;
      logic [15:0] push_m;
      logic [15:0] pop_m;
      logic [15:0] rv_m;
      int          rdy;
      logic [3:0]  pval;
      logic [3:0]  res;
   } vec_t;

   // kind 0 operand, 1 binary op, 2 DUP; offsets counted from the accept edge
   function automatic vec_t mk(input int kind, input logic [3:0] d,
                               input logic [3:0] pval, input logic [3:0] res);
      vec_t v;
      v.is_op = (kind != 0);
      v.data  = d;
      v.pval  = pval;
      v.res   = res;
      case (kind)
         0:       begin v.push_m = 16'h0002; v.pop_m = 16'h0000; v.rv_m = 16'h0000; v.rdy = 2; end
         1:       begin v.push_m = 16'h0040; v.pop_m = 16'h000A; v.rv_m = 16'h0040; v.rdy = 7; end
         default: begin v.push_m = 16'h0018; v.pop_m = 16'h0002; v.rv_m = 16'h0008; v.rdy = 5; end
      endcase
      return v;
   endfunction

   // Send one token and log stack/result activity per cycle after acceptance
   task automatic run_token(input logic is_op, input logic [3:0] data, input int max_cyc,
                            output logic [15:0] push_m, output logic [15:0] pop_m,
                            output logic [15:0] rv_m, output int rdy_off,
                            output logic [3:0] last_push);
      int w;
      w = 0;
      push_m = '0; pop_m = '0; rv_m = '0; rdy_off = 0; last_push = '0;
      while (!Tok_Ready && w < 30) begin
         @(negedge Clk);
         w++;
      end
      if (!Tok_Ready) begin
         chk("ready_wait_timeout", 0, 1);
      end else begin
         Tok_IsOp  = is_op;
         Tok_Data  = data;
         Tok_Valid = 1'b1;
         @(negedge Clk);
         Tok_Valid = 1'b0;
         for (int k = 1; k <= max_cyc; k++) begin
            @(negedge Clk);
            if (St_Push) begin
               push_m[k] = 1'b1;
               last_push = St_Data_In;
            end
            if (St_Pop) pop_m[k] = 1'b1;
            if (Result_Valid) rv_m[k] = 1'b1;
            if (St_Push && St_Pop) both_viol++;
            if (Tok_Ready) begin
               rdy_off = k;
               break;
            end
         end
      end
   endtask

   task automatic do_reset(input string name);
      @(negedge Clk);
      RstN = 1'b0;
      @(negedge Clk);
      RstN = 1'b1;
      chk({name, "_ready"}, int'(Tok_Ready), 0);
      chk({name, "_outs"}, int'({St_Push, St_Pop, St_Data_In, Result, Result_Valid, Busy, Err, Err_Code}), 0);
      @(negedge Clk);
      chk({name, "_ready_up"}, int'(Tok_Ready), 1);
   endtask

   vec_t        vecs [17];
   logic [15:0] pm, om, rm;
   int          ro;
   logic [3:0]  lp;
   int          pushes;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mk(0, 4'd3,  4'd3,  4'd0);
      vecs[1]  = mk(0, 4'd5,  4'd5,  4'd0);
      vecs[2]  = mk(1, 4'd0,  4'd8,  4'd8);
      vecs[3]  = mk(0, 4'd2,  4'd2,  4'd8);
      vecs[4]  = mk(0, 4'd7,  4'd7,  4'd8);
      vecs[5]  = mk(1, 4'd1,  4'd11, 4'd11);
      vecs[6]  = mk(0, 4'd15, 4'd15, 4'd11);
      vecs[7]  = mk(0, 4'd1,  4'd1,  4'd11);
      vecs[8]  = mk(1, 4'd0,  4'd0,  4'd0);
      vecs[9]  = mk(0, 4'd9,  4'd9,  4'd0);
      vecs[10] = mk(2, 4'd5,  4'd9,  4'd9);
      vecs[11] = mk(1, 4'd4,  4'd0,  4'd0);
      vecs[12] = mk(0, 4'd12, 4'd12, 4'd0);
      vecs[13] = mk(0, 4'd10, 4'd10, 4'd0);
      vecs[14] = mk(1, 4'd2,  4'd8,  4'd8);
      vecs[15] = mk(0, 4'd5,  4'd5,  4'd8);
      vecs[16] = mk(1, 4'd3,  4'd13, 4'd13);

      RstN = 1'b1; Tok_Valid = 1'b0; Tok_IsOp = 1'b0; Tok_Data = 4'd0;
      do_reset("reset");

      for (int i = 0; i < 17; i++) begin
         run_token(vecs[i].is_op, vecs[i].data, 12, pm, om, rm, ro, lp);
         chk($sformatf("v%0d_push_mask", i), int'(pm), int'(vecs[i].push_m));
         chk($sformatf("v%0d_pop_mask", i), int'(om), int'(vecs[i].pop_m));
         chk($sformatf("v%0d_rv_mask", i), int'(rm), int'(vecs[i].rv_m));
         chk($sformatf("v%0d_ready_off", i), ro, vecs[i].rdy);
         chk($sformatf("v%0d_push_val", i), int'(lp), int'(vecs[i].pval));
         chk($sformatf("v%0d_result", i), int'(Result), int'(vecs[i].res));
      end
      chk("table_err", int'(Err), 0);
      chk("table_depth", int'(cnt), 5);

      // Underflow: one operand then ADD
      do_reset("rst_uf");
      run_token(1'b0, 4'd4, 12, pm, om, rm, ro, lp);
      run_token(1'b1, 4'd0, 12, pm, om, rm, ro, lp);
      chk("uf_pop_mask", int'(om), 16'h0002);
      chk("uf_push_mask", int'(pm), 0);
      chk("uf_err", int'(Err), 1);
      chk("uf_code", int'(Err_Code), 1);
      chk("uf_ready", int'(Tok_Ready), 0);
      do_reset("rst_after_uf");

      // Overflow: ninth operand on a full stack
      for (int i = 0; i < 8; i++) run_token(1'b0, 4'(i), 12, pm, om, rm, ro, lp);
      chk("ov_depth8", int'(cnt), 8);
      run_token(1'b0, 4'd15, 12, pm, om, rm, ro, lp);
      chk("ov_push_mask", int'(pm), 0);
      chk("ov_depth", int'(cnt), 8);
      chk("ov_err", int'(Err), 1);
      chk("ov_code", int'(Err_Code), 2);

      // Illegal opcode straight from reset
      do_reset("rst_ov");
      run_token(1'b1, 4'd12, 12, pm, om, rm, ro, lp);
      chk("ill_stack_pulses", int'({pm, om}), 0);
      chk("ill_code", int'(Err_Code), 3);
      chk("ill_err", int'(Err), 1);
      chk("ill_busy", int'(Busy), 1);

      // Reset during WAIT_A of an ADD
      do_reset("rst_ill");
      run_token(1'b0, 4'd6, 12, pm, om, rm, ro, lp);
      run_token(1'b0, 4'd7, 12, pm, om, rm, ro, lp);
      run_token(1'b1, 4'd0, 12, pm, om, rm, ro, lp);
      chk("pre_mid_result", int'(Result), 13);
      run_token(1'b0, 4'd1, 12, pm, om, rm, ro, lp);
      run_token(1'b0, 4'd2, 12, pm, om, rm, ro, lp);
      Tok_IsOp = 1'b1; Tok_Data = 4'd0; Tok_Valid = 1'b1;
      @(negedge Clk);
      Tok_Valid = 1'b0;
      repeat (3) @(negedge Clk);
      chk("mid_busy", int'(Busy), 1);
      RstN = 1'b0;
      @(negedge Clk);
      RstN = 1'b1;
      chk("mid_rst_ready", int'(Tok_Ready), 0);
      chk("mid_rst_outs", int'({St_Push, St_Pop, St_Data_In, Result, Result_Valid, Busy, Err, Err_Code}), 0);
      pushes = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge Clk);
         if (St_Push) pushes++;
      end
      chk("mid_no_push", pushes, 0);
      chk("mid_ready_up", int'(Tok_Ready), 1);

      chk("push_pop_overlap", both_viol, 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/rpn_stack_master.md
# rpn_stack_master

Reverse-Polish evaluation controller that drives the team's 8-entry, 4-bit LIFO stack from its initiator side. Accepts a stream of operand/operator tokens over a valid/ready handshake and converts each into Push/Pop sequences on the stack port. Computes 4-bit arithmetic/logic results and pushes them back. Sits between the keypad/token front end and the stack block; the stack itself is external.

## Interface
- WIDTH, 4, data width of operands, results and stack entries
- Clk  in  1  clock; all logic on posedge
- RstN  in  1  reset, synchronous, active-low
- Tok_Valid  in  1  token present
- Tok_Ready  out  1  block can accept a token (high only in IDLE)
- Tok_IsOp  in  1  1 = operator token, 0 = operand token
- Tok_Data  in  WIDTH  operand value, or opcode when Tok_IsOp=1
- St_Push  out  1  push request to stack (one-cycle pulse)
- St_Pop  out  1  pop request to stack (one-cycle pulse)
- St_Data_In  out  WIDTH  value to push
- St_Data_Out  in  WIDTH  popped value; valid the cycle after St_Pop
- St_Full  in  1  stack holds 8 entries
- St_Empty  in  1  stack flag, HIGH when the stack holds at least one entry (stack's native polarity)
- Result  out  WIDTH  last computed result
- Result_Valid  out  1  one-cycle pulse when Result updates
- Busy  out  1  state != IDLE
- Err  out  1  sticky error; cleared only by reset
- Err_Code  out  2  1 underflow, 2 overflow, 3 illegal opcode; 0 none

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 DUP; 6..15 illegal. B = top of stack, A = next.
- Arithmetic mod 2^WIDTH; carry/borrow discarded.
- FSM states: IDLE, PUSH_OPND, POP_B, WAIT_B, POP_A, WAIT_A, EXEC, PUSH_RES, PUSH_DUP, ERROR.
- IDLE: Tok_Ready=1; on Tok_Valid: latch token; operand -> PUSH_OPND; legal op -> POP_B; illegal op -> ERROR (code 3).
- PUSH_OPND: if St_Full -> ERROR (code 2), no push; else St_Push=1, St_Data_In=operand -> IDLE.
- POP_B: if St_Empty=0 -> ERROR (code 1); else St_Pop=1 -> WAIT_B.
- WAIT_B: capture St_Data_Out into B; DUP -> PUSH_RES; else -> POP_A.
- POP_A: flag reflects post-pop count; if St_Empty=0 -> ERROR (code 1), B is lost; else St_Pop=1 -> WAIT_A.
- WAIT_A: capture A -> EXEC. EXEC: compute R (registered) -> PUSH_RES.
- PUSH_RES: St_Push=1, St_Data_In=R (DUP: B); Result<=R/B, Result_Valid=1; DUP -> PUSH_DUP else IDLE.
- PUSH_DUP: if St_Full -> ERROR (code 2); else St_Push=1, St_Data_In=B -> IDLE.
- ERROR: Tok_Ready=0, no stack activity, Err=1 held until reset. Err_Code records first error only.
- St_Push and St_Pop never asserted in the same cycle; never asserted in IDLE or ERROR.

## Timing
- Reset (RstN=0 at posedge): state IDLE, Tok_Ready=0 during reset cycle then 1, St_Push=0, St_Pop=0, St_Data_In=0, Result=0, Result_Valid=0, Busy=0, Err=0, Err_Code=0. Reset mid-sequence aborts immediately; partially popped operands discarded; stack reset is the system's responsibility.
- Operand accepted at edge T: St_Push high cycle T+1; Tok_Ready back high T+2.
- Binary op accepted at T: St_Pop at T+1 and T+3, St_Push + Result_Valid at T+6, Tok_Ready high at T+7.
- DUP accepted at T: St_Pop T+1, St_Push T+3 and T+4, Result_Valid T+3, Tok_Ready T+5.
- Flags sampled in the cycle the request would be asserted; stack flags are assumed valid one cycle after each push/pop.
- Tok_Valid while Tok_Ready=0 is ignored (token held by sender).

## Test plan
- Reset, then tokens 3, 5, ADD -> pushes 3, 5; pops 5 then 3; push 8, Result=8 with one Result_Valid pulse at T+6.
- Tokens 2, 7, SUB -> Result=11 (2−7 mod 16); tokens 15, 1, ADD -> Result=0.
- Token 9, DUP, XOR -> pushes 9, 9, Result 9 on DUP, then Result=0 after XOR.
- Single operand 4 then ADD -> one pop, then Err=1, Err_Code=1, Tok_Ready stays 0; RstN low one cycle clears Err.
- Nine operands (stack full after eight) -> ninth not pushed, Err_Code=2; opcode 12 from reset -> Err_Code=3, no stack pulses.
- Assert RstN=0 during WAIT_A of an ADD -> next cycle IDLE, all outputs at reset values, no St_Push issued.
